vcve2_dmem_responder: RTL and testbench

- Memory-side responder for the CVE2/vector data memory port: the far end of the req/gnt/rvalid interface that the dmem switch drives per port.
- Accepts requests, grants them after a configurable wait, performs byte-enabled SRAM reads and writes, and returns rvalid/rdata/err after a fixed response latency.
- One instance per data port, used in simulation top-levels and FPGA builds; it backpressures through gnt and limits the number of requests in flight.

---
 rtl/vcve2_dmem_responder.sv | 186 ++++++++++++++++++
 tb/tb_vcve2_dmem_responder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcve2_dmem_responder.sv
// Memory-side responder for a req/gnt/rvalid data port: grants after a fixed wait,
// performs byte-enabled SRAM accesses and returns responses after a fixed latency.
module vcve2_dmem_responder #(
  parameter int          MemWords       = 1024,
  parameter logic [31:0] AddrBase       = 32'h0,
  parameter int          GntLatency     = 0,
  parameter int          RespLatency    = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        stall_i
);

  localparam int              IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int              OutW     = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0] OutMax   = OutW'(MaxOutstanding);
  // The IDLE cycle that sees req counts as the first wait cycle, so WAIT starts one lower.
  localparam logic [2:0]      GntLoad  = (GntLatency > 0) ? 3'(GntLatency - 1) : 3'd0;
  localparam logic [29:0]     BaseWord = AddrBase[31:2];

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [OutW-1:0]        outst_q, outst_d;
  logic [RespLatency-1:0] vld_q, vld_d;
  logic [RespLatency-1:0] err_q, err_d;
  logic                   gnt_ok;
  logic                   gnt;
  logic                   rsp_valid;
  logic [31:0]            rsp_data;

  logic [29:0]     word_addr;
  logic [29:0]     word_off;
  logic            oor;
  logic [IdxW-1:0] idx;
  logic            wr_en;
  logic            rd_en;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^data_addr_i[1:0];

  assign word_addr = data_addr_i[31:2];
  assign word_off  = word_addr - BaseWord;
  assign oor       = (word_addr < BaseWord) || ({2'b00, word_off} >= 32'(MemWords));
  assign idx       = word_off[IdxW-1:0];

  assign gnt_ok = !stall_i && (outst_q < OutMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_req_i) begin
          if (GntLatency == 0) begin
            gnt = gnt_ok;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = GntLoad;
          end
        end
      end
      ST_WAIT: begin
        if (!data_req_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (gnt_ok) begin
          gnt     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst_i) begin
      gnt = 1'b0;
    end
  end

  assign wr_en = gnt && data_we_i && !oor;
  assign rd_en = gnt && !data_we_i && !oor;

  logic [31:0] mem [MemWords];
  logic [31:0] rd_word_q;

  // Read-first RAM; the read register doubles as the first response data stage.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) begin
          mem[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
    if (rst_i || !rd_en) begin
      rd_word_q <= '0;
    end else begin
      rd_word_q <= mem[idx];
    end
  end

  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    vld_d[0] = gnt;
    err_d[0] = gnt && oor;
    for (int k = 1; k < RespLatency; k++) begin
      vld_d[k] = vld_q[k-1];
      err_d[k] = err_q[k-1];
    end
  end

  generate
    if (RespLatency == 1) begin : g_data_direct
      assign rsp_data = rd_word_q;
    end else begin : g_data_pipe
      logic [31:0] data_q [RespLatency-1];
      logic [31:0] data_d [RespLatency-1];

      always_comb begin
        data_d[0] = rd_word_q;
        for (int k = 1; k < RespLatency - 1; k++) begin
          data_d[k] = data_q[k-1];
        end
      end

      always_ff @(posedge clk_i) begin
        for (int k = 0; k < RespLatency - 1; k++) begin
          data_q[k] <= rst_i ? '0 : data_d[k];
        end
      end

      assign rsp_data = data_q[RespLatency-2];
    end
  endgenerate

  assign rsp_valid = vld_q[RespLatency-1];

  // A retiring response does not free its slot until the next cycle.
  always_comb begin
    outst_d = outst_q;
    if (gnt && !rsp_valid) begin
      outst_d = outst_q + OutW'(1);
    end else if (!gnt && rsp_valid) begin
      outst_d = outst_q - OutW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      outst_q <= '0;
      vld_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rsp_valid && !rst_i;
  assign data_err_o    = rsp_valid && !rst_i && err_q[RespLatency-1];
  assign data_rdata_o  = (rsp_valid && !rst_i) ? rsp_data : '0;

  a_outst_max : assert property (@(posedge clk_i) disable iff (rst_i) outst_q <= OutMax);
  a_outst_min : assert property (@(posedge clk_i) disable iff (rst_i)
                                 !(rsp_valid && !gnt && outst_q == '0));

endmodule

// File: tb/tb_vcve2_dmem_responder.sv
// Bench for vcve2_dmem_responder: three differently configured instances checked every
// cycle against a cycle-arithmetic model, plus directed scenarios with literal expectations.
module tb_vcve2_dmem_responder;

  localparam int NI = 3;

  function automatic int cfg_g(input int i);
    return (i == 1) ? 2 : 0;
  endfunction
  function automatic int cfg_r(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction
  function automatic int cfg_m(input int i);
    return (i == 2) ? 1 : 2;
  endfunction
  function automatic int cfg_mw(input int i);
    return (i == 0) ? 1024 : ((i == 1) ? 64 : 16);
  endfunction
  function automatic logic [31:0] cfg_base(input int i);
    return (i == 0) ? 32'h0 : ((i == 1) ? 32'h1000 : 32'h200);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst   [NI];
  logic        req   [NI];
  logic        we    [NI];
  logic        stall [NI];
  logic [3:0]  be    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic        gnt   [NI];
  logic        rvalid[NI];
  logic        err   [NI];
  logic [31:0] rdata [NI];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          inst;
    bit          is_rv;
    int          cyc;
    logic [31:0] d;
    logic        e;
  } ev_t;
  ev_t ev_log[$];

  typedef struct {
    int          due;
    bit          e;
    logic [31:0] d;
    bit          known;
  } rsp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int ev_cnt(input int i, input bit rv);
    int n = 0;
    foreach (ev_log[j]) if (ev_log[j].inst == i && ev_log[j].is_rv == rv) n++;
    return n;
  endfunction

  function automatic ev_t ev_nth(input int i, input bit rv, input int k);
    ev_t r;
    int  n = 0;
    r.inst = -1; r.is_rv = rv; r.cyc = -1000; r.d = 32'hFFFF_FFFF; r.e = 1'bx;
    foreach (ev_log[j]) begin
      if (ev_log[j].inst == i && ev_log[j].is_rv == rv) begin
        if (n == k) return ev_log[j];
        n++;
      end
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int          G    = cfg_g(gi);
    localparam int          R    = cfg_r(gi);
    localparam int          M    = cfg_m(gi);
    localparam int          MW   = cfg_mw(gi);
    localparam logic [31:0] BASE = cfg_base(gi);

    vcve2_dmem_responder #(
      .MemWords(MW), .AddrBase(BASE), .GntLatency(G), .RespLatency(R), .MaxOutstanding(M)
    ) u_dut (
      .clk_i(clk), .rst_i(rst[gi]),
      .data_req_i(req[gi]), .data_gnt_o(gnt[gi]), .data_rvalid_o(rvalid[gi]),
      .data_we_i(we[gi]), .data_be_i(be[gi]), .data_addr_i(addr[gi]),
      .data_wdata_i(wdata[gi]), .data_rdata_o(rdata[gi]), .data_err_o(err[gi]),
      .stall_i(stall[gi])
    );

    // Model: a request that started at cycle st is granted in the first cycle
    // >= st+G without stall and with fewer than M responses pending.
    rsp_t        q[$];
    logic [31:0] mm [int];
    logic [3:0]  mk [int];
    int          st = -1;

    always @(negedge clk) begin : p_cmp
      bit          ge, re, oo, known, ee;
      logic [31:0] ed, tmp;
      int          wi;
      rsp_t        n;
      if (rst[gi]) begin
        chk($sformatf("i%0d rst gnt", gi), 32'(gnt[gi]), 32'h0);
        chk($sformatf("i%0d rst rvalid", gi), 32'(rvalid[gi]), 32'h0);
        chk($sformatf("i%0d rst rdata", gi), rdata[gi], 32'h0);
        chk($sformatf("i%0d rst err", gi), 32'(err[gi]), 32'h0);
        q.delete();
        st = -1;
      end else begin
        if (req[gi] && st < 0) st = cyc;
        ge    = req[gi] && (cyc >= st + G) && !stall[gi] && (q.size() < M);
        re    = (q.size() > 0) && (q[0].due == cyc);
        ed    = re ? q[0].d : 32'h0;
        ee    = re && q[0].e;
        known = !re || q[0].known;
        chk($sformatf("i%0d c%0d gnt", gi, cyc), 32'(gnt[gi]), 32'(ge));
        chk($sformatf("i%0d c%0d rvalid", gi, cyc), 32'(rvalid[gi]), 32'(re));
        chk($sformatf("i%0d c%0d err", gi, cyc), 32'(err[gi]), 32'(ee));
        if (known) chk($sformatf("i%0d c%0d rdata", gi, cyc), rdata[gi], ed);
        if (gnt[gi]) ev_log.push_back('{inst: gi, is_rv: 1'b0, cyc: cyc, d: 32'h0, e: 1'b0});
        if (rvalid[gi]) ev_log.push_back('{inst: gi, is_rv: 1'b1, cyc: cyc, d: rdata[gi], e: err[gi]});
        if (re) void'(q.pop_front());
        if (ge) begin
          oo = (addr[gi] < BASE) || (((addr[gi] - BASE) >> 2) >= 32'(MW));
          wi = int'((addr[gi] - BASE) >> 2);
          n.due = cyc + R; n.e = oo; n.d = 32'h0; n.known = 1'b1;
          if (!oo) begin
            if (we[gi]) begin
              if (!mm.exists(wi)) begin mm[wi] = 32'h0; mk[wi] = 4'h0; end
              tmp = mm[wi];
              for (int b = 0; b < 4; b++) begin
                if (be[gi][b]) tmp[8*b +: 8] = wdata[gi][8*b +: 8];
              end
              mm[wi] = tmp;
              mk[wi] = mk[wi] | be[gi];
            end else begin
              n.known = mk.exists(wi) && (mk[wi] == 4'hF);
              n.d     = n.known ? mm[wi] : 32'h0;
            end
          end
          q.push_back(n);
          st = -1;
        end
        if (!req[gi]) st = -1;
      end
    end
  end

  task automatic cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge following the grant,
  // with req still asserted so back-to-back requests are possible.
  task automatic issue(input int i, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic [15:0] smask, input bit srand,
                       output int t0, output int lat);
    t0 = cyc; lat = -1;
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    for (int k = 0; k < 64; k++) begin
      stall[i] = srand ? ($urandom_range(0, 2) == 0) : ((k < 16) ? smask[k] : 1'b0);
      @(negedge clk);
      if (gnt[i]) begin
        lat = cyc - t0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    stall[i] = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL i%0d grant timeout: no gnt within 64 cycles, addr=%08h", i, a);
    end else begin
      $display("i%0d txn we=%0b be=%h addr=%08h wdata=%08h gnt_lat=%0d", i, w, b, a, d, lat);
    end
  endtask

  task automatic rand_traffic(input int i, input int n);
    int          t0, lat, r;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 15);
      if (r == 0) a = cfg_base(i) + 32'(cfg_mw(i) * 4) + 32'(4 * $urandom_range(0, 3));
      else if (r == 1 && cfg_base(i) != 0) a = cfg_base(i) - 32'd4;
      else a = cfg_base(i) + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      issue(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, 16'h0, 1'b1, t0, lat);
      if ($urandom_range(0, 2) != 0) begin
        req[i] = 1'b0;
        cycles($urandom_range(0, 3));
      end
    end
    req[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0, lat;
    ev_t e, g;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; stall[i] = 1'b0;
      be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h10;
    @(posedge clk); #1;
    cycles(2);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    req[0] = 1'b0;
    chk("no gnt/rvalid while in reset", 32'(ev_log.size()), 32'h0);

    // Default config: full write then read.
    ev_log.delete();
    issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 16'h0, 1'b0, t0, lat);
    chk("A write gnt latency", 32'(lat), 32'h0);
    req[0] = 1'b0;
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 16'h0, 1'b0, t0, lat);
    chk("A read gnt latency", 32'(lat), 32'h0);
    req[0] = 1'b0;
    cycles(3);
    e = ev_nth(0, 1'b1, 0);
    chk("A write response rdata", e.d, 32'h0);
    g = ev_nth(0, 1'b0, 1);
    e = ev_nth(0, 1'b1, 1);
    chk("A read rvalid delay", 32'(e.cyc - g.cyc), 32'h1);
    chk("A read rdata", e.d, 32'hDEADBEEF);
    chk("A read err", 32'(e.e), 32'h0);

    // Partial write.
    ev_log.delete();
    issue(0, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 16'h0, 1'b0, t0, lat); req[0] = 1'b0;
    issue(0, 1'b1, 4'b0101, 32'h20, 32'h11223344, 16'h0, 1'b0, t0, lat); req[0] = 1'b0;
    issue(0, 1'b0, 4'hF, 32'h20, 32'h0, 16'h0, 1'b0, t0, lat); req[0] = 1'b0;
    cycles(3);
    e = ev_nth(0, 1'b1, 2);
    chk("A partial write merge", e.d, 32'hDE22BE44);

    // Out of range read and write, then an in-range read.
    ev_log.delete();
    issue(0, 1'b0, 4'hF, 32'h1000, 32'h0, 16'h0, 1'b0, t0, lat); req[0] = 1'b0;
    issue(0, 1'b1, 4'hF, 32'h1010, 32'h55555555, 16'h0, 1'b0, t0, lat); req[0] = 1'b0;
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 16'h0, 1'b0, t0, lat); req[0] = 1'b0;
    cycles(3);
    e = ev_nth(0, 1'b1, 0);
    chk("A oor read err", 32'(e.e), 32'h1);
    chk("A oor read rdata", e.d, 32'h0);
    e = ev_nth(0, 1'b1, 1);
    chk("A oor write err", 32'(e.e), 32'h1);
    e = ev_nth(0, 1'b1, 2);
    chk("A read after oor err", 32'(e.e), 32'h0);
    chk("A read after oor rdata", e.d, 32'hDEADBEEF);

    // GntLatency=2, RespLatency=3, with and without stall.
    issue(1, 1'b1, 4'hF, 32'h1004, 32'hCAFEF00D, 16'h0, 1'b0, t0, lat);
    chk("B write gnt latency", 32'(lat), 32'h2);
    req[1] = 1'b0;
    cycles(4);
    ev_log.delete();
    issue(1, 1'b0, 4'hF, 32'h1004, 32'h0, 16'h0, 1'b0, t0, lat);
    chk("B read gnt latency", 32'(lat), 32'h2);
    req[1] = 1'b0;
    cycles(5);
    e = ev_nth(1, 1'b1, 0);
    chk("B read rvalid cycle", 32'(e.cyc - t0), 32'h5);
    chk("B read rdata", e.d, 32'hCAFEF00D);
    ev_log.delete();
    issue(1, 1'b0, 4'hF, 32'h1004, 32'h0, 16'h000C, 1'b0, t0, lat);
    chk("B stalled gnt latency", 32'(lat), 32'h4);
    req[1] = 1'b0;
    cycles(8);
    chk("B stalled rvalid count", 32'(ev_cnt(1, 1'b1)), 32'h1);
    e = ev_nth(1, 1'b1, 0);
    chk("B stalled rvalid cycle", 32'(e.cyc - t0), 32'h7);

    // MaxOutstanding=1, RespLatency=2, req continuously high.
    ev_log.delete();
    issue(2, 1'b1, 4'hF, 32'h200, 32'hA5A50001, 16'h0, 1'b0, t0, lat);
    issue(2, 1'b1, 4'hF, 32'h204, 32'hA5A50002, 16'h0, 1'b0, g.cyc, lat);
    issue(2, 1'b0, 4'hF, 32'h200, 32'h0, 16'h0, 1'b0, g.cyc, lat);
    req[2] = 1'b0;
    cycles(10);
    for (int k = 0; k < 3; k++) begin
      g = ev_nth(2, 1'b0, k);
      e = ev_nth(2, 1'b1, k);
      chk($sformatf("C gnt %0d cycle", k), 32'(g.cyc - t0), 32'(3 * k));
      chk($sformatf("C rvalid %0d cycle", k), 32'(e.cyc - t0), 32'(3 * k + 2));
    end
    chk("C read rdata", e.d, 32'hA5A50001);

    // Reset between a read grant and its response.
    issue(1, 1'b0, 4'hF, 32'h1004, 32'h0, 16'h0, 1'b0, t0, lat);
    req[1] = 1'b0;
    rst[1] = 1'b1;
    ev_log.delete();
    cycles(1);
    rst[1] = 1'b0;
    cycles(6);
    chk("B no rvalid after reset", 32'(ev_cnt(1, 1'b1)), 32'h0);
    issue(1, 1'b0, 4'hF, 32'h1004, 32'h0, 16'h0, 1'b0, t0, lat);
    chk("B gnt latency after reset", 32'(lat), 32'h2);
    req[1] = 1'b0;
    cycles(5);
    chk("B rvalid count after reset", 32'(ev_cnt(1, 1'b1)), 32'h1);
    e = ev_nth(1, 1'b1, 0);
    chk("B rdata kept across reset", e.d, 32'hCAFEF00D);

    fork
      rand_traffic(0, 300);
      rand_traffic(1, 300);
      rand_traffic(2, 300);
    join
    cycles(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
